// File: rtl/machine_cfg_pkg.sv
// Shared types and helpers for the GF(2) machine configuration solver.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package machine_cfg_pkg;

  localparam int DEF_NUM_LIGHTS  = 10;
  localparam int DEF_NUM_BUTTONS = 13;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ELIM,
    CHECK,
    ENUM,
    EMIT
  } state_t;

  // One augmented matrix row: button columns plus the target bit on top.
  typedef logic [DEF_NUM_BUTTONS:0] row_t;

  // Index/count width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf2_pivot_step.sv
// One Gauss-Jordan column step over GF(2): pivot search, swap into place, XOR elimination.
// Latency: combinational.
// Backpressure: none; the caller decides when to commit o_rows.
module gf2_pivot_step
  import machine_cfg_pkg::*;
#(
  parameter int NL = 10,
  parameter int NB = 13,
  parameter int LW = clog2_min1(NL + 1),
  parameter int BW = clog2_min1(NB + 1)
) (
  input  logic [NL-1:0][NB:0] i_rows,
  input  logic [BW-1:0]       i_col,
  input  logic [LW-1:0]       i_prow,
  input  logic [LW-1:0]       i_nl,
  output logic [NL-1:0][NB:0] o_rows,
  output logic                o_found
);

  logic [LW-1:0]       w_sel;
  logic [NB:0]         w_piv;
  logic [NL-1:0][NB:0] w_swapped;

  // Lowest active row at or below the pivot position with the column bit set;
  // scanning downward from the top index lets the lowest match win.
  always_comb begin
    o_found = 1'b0;
    w_sel   = '0;
    for (int r = NL - 1; r >= 0; r--) begin
      if (r >= int'(i_prow) && r < int'(i_nl) && i_rows[r][i_col]) begin
        o_found = 1'b1;
        w_sel   = LW'(r);
      end
    end
  end

  // Swap the pivot row into place, then clear the column from every other active row.
  always_comb begin
    w_piv             = i_rows[w_sel];
    w_swapped         = i_rows;
    w_swapped[w_sel]  = i_rows[i_prow];
    w_swapped[i_prow] = w_piv;
    o_rows            = i_rows;
    if (o_found) begin
      o_rows = w_swapped;
      for (int r = 0; r < NL; r++) begin
        if (r != int'(i_prow) && r < int'(i_nl) && w_swapped[r][i_col]) begin
          o_rows[r] = w_swapped[r] ^ w_piv;
        end
      end
    end
  end

endmodule

// File: rtl/popcount.sv
// Population count of a bit vector.
// Latency: combinational.
// Backpressure: none (pure function of the input).
module popcount
  import machine_cfg_pkg::*;
#(
  parameter int W = 13
) (
  input  logic [W-1:0]                  i_bits,
  output logic [clog2_min1(W+1)-1:0]    o_count
);

  localparam int CW = clog2_min1(W + 1);

  // Sum every set bit.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/machine_config_solver.sv
// Streaming GF(2) solver: RREF one column per cycle, then exhaustive free-variable search for min presses.
// Latency: 2 + num_buttons (+ 2^free when feasible) cycles from input handshake to out_valid.
// Backpressure: in_ready only in IDLE; result held stable in EMIT until out_ready.
module machine_config_solver
  import machine_cfg_pkg::*;
#(
  parameter int MAX_NUM_LIGHTS  = DEF_NUM_LIGHTS,
  parameter int MAX_NUM_BUTTONS = DEF_NUM_BUTTONS,
  parameter int MAX_FREE        = MAX_NUM_BUTTONS,
  parameter int SUM_W           = 32
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [clog2_min1(MAX_NUM_LIGHTS+1)-1:0]     num_lights,
  input  logic [clog2_min1(MAX_NUM_BUTTONS+1)-1:0]    num_buttons,
  input  logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons,
  input  logic [MAX_NUM_LIGHTS-1:0]                   target,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [clog2_min1(MAX_NUM_BUTTONS+1)-1:0]    out_presses,
  output logic [MAX_NUM_BUTTONS-1:0]                  out_mask,
  output logic                                        out_infeasible,
  output logic [SUM_W-1:0]                            total_presses,
  input  logic                                        total_clear
);

  localparam int L  = MAX_NUM_LIGHTS;
  localparam int B  = MAX_NUM_BUTTONS;
  localparam int LW = clog2_min1(L + 1);
  localparam int BW = clog2_min1(B + 1);
  localparam int KW = MAX_FREE + 1;
  localparam logic [KW-1:0] K_ONE = KW'(1);

  state_t               r_state, w_next;
  logic                 r_in_ready;
  logic [L-1:0][B:0]    r_rows;
  logic [LW-1:0]        r_nl, r_prow;
  logic [BW-1:0]        r_nb, r_col, r_nfree;
  logic [L-1:0][BW-1:0] r_pivot_of;
  logic [B-1:0]         r_free_mask;
  logic [KW-1:0]        r_k;
  logic [BW-1:0]        r_best_cnt;
  logic [B-1:0]         r_best_mask;
  logic                 r_out_valid, r_out_inf;
  logic [BW-1:0]        r_out_presses;
  logic [B-1:0]         r_out_mask;
  logic [SUM_W-1:0]     r_total;

  logic [L-1:0][B:0]    w_load_rows, w_step_rows;
  logic                 w_step_found, w_infeasible, w_elim_last, w_k_last;
  logic                 w_in_hs, w_out_hs;
  logic [BW-1:0]        w_free_cnt, w_cnt, w_best_cnt_nxt, w_j;
  logic [B-1:0]         w_free_x, w_x, w_best_mask_nxt;
  logic [SUM_W:0]       w_sum;
  logic [SUM_W-1:0]     w_total_sat;

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_presses    = r_out_presses;
  assign out_mask       = r_out_mask;
  assign out_infeasible = r_out_inf;
  assign total_presses  = r_total;

  assign w_in_hs     = in_valid & r_in_ready;
  assign w_out_hs    = r_out_valid & out_ready;
  assign w_elim_last = (r_col == r_nb - BW'(1));
  assign w_k_last    = (r_k == ((K_ONE << r_nfree) - K_ONE));
  assign w_sum       = {1'b0, r_total} + (SUM_W + 1)'(r_out_presses);
  assign w_total_sat = w_sum[SUM_W] ? {SUM_W{1'b1}} : w_sum[SUM_W-1:0];

  gf2_pivot_step #(.NL(L), .NB(B), .LW(LW), .BW(BW)) u_step (
    .i_rows  (r_rows),
    .i_col   (r_col),
    .i_prow  (r_prow),
    .i_nl    (r_nl),
    .o_rows  (w_step_rows),
    .o_found (w_step_found)
  );

  popcount #(.W(B)) u_free_cnt (
    .i_bits  (r_free_mask),
    .o_count (w_free_cnt)
  );

  popcount #(.W(B)) u_cand_cnt (
    .i_bits  (w_x),
    .o_count (w_cnt)
  );

  // Build the augmented matrix from the descriptor; inactive rows/columns stay zero.
  always_comb begin
    w_load_rows = '0;
    for (int r = 0; r < L; r++) begin
      if (r < int'(num_lights)) begin
        w_load_rows[r][B] = target[r];
        for (int c = 0; c < B; c++) begin
          if (c < int'(num_buttons)) w_load_rows[r][c] = buttons[c][r];
        end
      end
    end
  end

  // A zero-variable row below the rank with a set target bit means no solution.
  always_comb begin
    w_infeasible = 1'b0;
    for (int r = 0; r < L; r++) begin
      if (r >= int'(r_prow) && r < int'(r_nl) && r_rows[r][B]) w_infeasible = 1'b1;
    end
  end

  // Candidate assignment: free columns take k's bits in ascending order, pivots follow from RREF.
  always_comb begin
    w_free_x = '0;
    w_j      = '0;
    for (int c = 0; c < B; c++) begin
      if (r_free_mask[c]) begin
        if (int'(w_j) < KW) w_free_x[c] = r_k[w_j];
        w_j = w_j + BW'(1);
      end
    end
    w_x = w_free_x;
    for (int r = 0; r < L; r++) begin
      if (r < int'(r_prow)) begin
        w_x[r_pivot_of[r]] = r_rows[r][B] ^ (^(r_rows[r][B-1:0] & w_free_x));
      end
    end
  end

  // Strictly-smaller update keeps the earliest k on ties.
  always_comb begin
    w_best_cnt_nxt  = r_best_cnt;
    w_best_mask_nxt = r_best_mask;
    if (w_cnt < r_best_cnt) begin
      w_best_cnt_nxt  = w_cnt;
      w_best_mask_nxt = w_x;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_in_hs) w_next = LOAD;
      LOAD:    w_next = (r_nb == '0) ? CHECK : ELIM;
      ELIM:    if (w_elim_last) w_next = CHECK;
      CHECK:   w_next = w_infeasible ? EMIT : ENUM;
      ENUM:    if (w_k_last) w_next = EMIT;
      EMIT:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath, result registers and the saturating running total.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready    <= 1'b0;
      r_rows        <= '0;
      r_nl          <= '0;
      r_nb          <= '0;
      r_col         <= '0;
      r_prow        <= '0;
      r_pivot_of    <= '0;
      r_free_mask   <= '0;
      r_nfree       <= '0;
      r_k           <= '0;
      r_best_cnt    <= '1;
      r_best_mask   <= '0;
      r_out_valid   <= 1'b0;
      r_out_inf     <= 1'b0;
      r_out_presses <= '0;
      r_out_mask    <= '0;
      r_total       <= '0;
    end else begin
      r_in_ready <= (w_next == IDLE);
      case (r_state)
        IDLE: begin
          if (w_in_hs) begin
            r_rows <= w_load_rows;
            r_nl   <= num_lights;
            r_nb   <= num_buttons;
          end
        end
        LOAD: begin
          r_col       <= '0;
          r_prow      <= '0;
          r_free_mask <= '0;
          r_pivot_of  <= '0;
        end
        ELIM: begin
          if (w_step_found) begin
            r_rows             <= w_step_rows;
            r_pivot_of[r_prow] <= r_col;
            r_prow             <= r_prow + LW'(1);
          end else begin
            r_free_mask[r_col] <= 1'b1;
          end
          if (!w_elim_last) r_col <= r_col + BW'(1);
        end
        CHECK: begin
          r_k         <= '0;
          r_best_cnt  <= '1;
          r_best_mask <= '0;
          r_nfree     <= w_free_cnt;
          if (w_infeasible) begin
            r_out_valid   <= 1'b1;
            r_out_inf     <= 1'b1;
            r_out_presses <= '0;
            r_out_mask    <= '0;
          end
        end
        ENUM: begin
          r_best_cnt  <= w_best_cnt_nxt;
          r_best_mask <= w_best_mask_nxt;
          if (w_k_last) begin
            r_out_valid   <= 1'b1;
            r_out_inf     <= 1'b0;
            r_out_presses <= w_best_cnt_nxt;
            r_out_mask    <= w_best_mask_nxt;
          end else begin
            r_k <= r_k + K_ONE;
          end
        end
        EMIT: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
      if (w_out_hs && total_clear) r_total <= r_out_inf ? '0 : SUM_W'(r_out_presses);
      else if (total_clear)        r_total <= '0;
      else if (w_out_hs && !r_out_inf) r_total <= w_total_sat;
    end
  end

endmodule

// File: tb/tb_machine_config_solver.sv
module tb_machine_config_solver;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        num_lights;
  logic [3:0]        num_buttons;
  logic [12:0][9:0]  buttons;
  logic [9:0]        target;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_presses;
  logic [12:0]       out_mask;
  logic              out_infeasible;
  logic [31:0]       total_presses;
  logic              total_clear;

  int     checks = 0;
  int     errors = 0;
  longint exp_total = 0;

  typedef struct {
    int               nl;
    int               nb;
    logic [12:0][9:0] btn;
    logic [9:0]       tgt;
  } mach_t;

  machine_config_solver dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .num_lights(num_lights), .num_buttons(num_buttons), .buttons(buttons), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_presses(out_presses),
    .out_mask(out_mask), .out_infeasible(out_infeasible),
    .total_presses(total_presses), .total_clear(total_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [9:0] lmask(input int nl);
    logic [10:0] t;
    t = (11'd1 << nl) - 11'd1;
    return t[9:0];
  endfunction

  // Light pattern produced by pressing the buttons in mask once each.
  function automatic logic [9:0] effect(input mach_t m, input logic [12:0] mask);
    logic [9:0] acc;
    acc = '0;
    for (int b = 0; b < m.nb; b++) if (mask[b]) acc ^= m.btn[b];
    return acc & lmask(m.nl);
  endfunction

  // Brute force over all press masks: feasibility, minimum presses, free count from null-space size.
  function automatic void model(input mach_t m, output bit feas, output int minp, output int nfree);
    int         sols0;
    logic [9:0] acc;
    sols0 = 0; feas = 0; minp = 0;
    for (int s = 0; s < (1 << m.nb); s++) begin
      acc = effect(m, 13'(s));
      if (acc == 10'd0) sols0++;
      if (acc == (m.tgt & lmask(m.nl)) && (!feas || $countones(s) < minp)) begin
        feas = 1; minp = $countones(s);
      end
    end
    nfree = $clog2(sols0);
  endfunction

  function automatic mach_t mk(input int nl, input int nb, input logic [9:0] tgt,
                               input logic [9:0] b0, input logic [9:0] b1, input logic [9:0] b2,
                               input logic [9:0] b3, input logic [9:0] b4, input logic [9:0] b5);
    mach_t m;
    m.nl = nl; m.nb = nb; m.tgt = tgt; m.btn = '0;
    m.btn[0] = b0; m.btn[1] = b1; m.btn[2] = b2; m.btn[3] = b3; m.btn[4] = b4; m.btn[5] = b5;
    return m;
  endfunction

  function automatic int exp_lat(input mach_t m);
    bit f; int p, nf;
    model(m, f, p, nf);
    return f ? (2 + m.nb + (1 << nf)) : (2 + m.nb);
  endfunction

  task automatic send_one(input mach_t m, output bit to);
    int n;
    @(negedge clk);
    num_lights = 4'(m.nl); num_buttons = 4'(m.nb); buttons = m.btn; target = m.tgt;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    to = (n >= 64);
    @(posedge clk); #1;
    in_valid = 1'b0;
    buttons = 130'({$urandom, $urandom, $urandom, $urandom, $urandom});
    target = 10'($urandom); num_lights = 4'($urandom); num_buttons = 4'($urandom);
  endtask

  task automatic wait_out(output int lat, output bit to);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20000) begin @(posedge clk); #1; lat++; end
    to = (out_valid !== 1'b1);
  endtask

  task automatic run_one(input mach_t m, output int lat, output bit to);
    bit t1, t2;
    send_one(m, t1);
    wait_out(lat, t2);
    to = t1 | t2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; total_clear = 1'b0;
    num_lights = '0; num_buttons = '0; buttons = '0; target = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_presses !== 4'd0) begin errors++; $display("FAIL reset_presses: got %0d want 0", out_presses); end
    checks++; if (out_mask !== 13'd0) begin errors++; $display("FAIL reset_mask: got %h want 0", out_mask); end
    checks++; if (out_infeasible !== 1'b0) begin errors++; $display("FAIL reset_infeasible: got %b want 0", out_infeasible); end
    checks++; if (total_presses !== 32'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", total_presses); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    exp_total = 0;
  endtask

  task automatic test_example;
    mach_t m; int lat; bit to, f; int p, nf;
    m = mk(4, 6, 10'h006, 10'h008, 10'h00A, 10'h004, 10'h00C, 10'h005, 10'h003);
    model(m, f, p, nf);
    run_one(m, lat, to);
    checks++; if (to) begin errors++; $display("FAIL example_timeout: got timeout want out_valid"); end
    checks++; if (out_presses !== 4'd2) begin errors++; $display("FAIL example_presses: got %0d want 2", out_presses); end
    checks++; if (out_infeasible !== 1'b0) begin errors++; $display("FAIL example_infeasible: got %b want 0", out_infeasible); end
    checks++; if (effect(m, out_mask) !== m.tgt) begin errors++; $display("FAIL example_mask_effect: got %h want %h", effect(m, out_mask), m.tgt); end
    checks++; if (lat != exp_lat(m)) begin errors++; $display("FAIL example_latency: got %0d want %0d", lat, exp_lat(m)); end
    @(posedge clk); #1;
    exp_total += p;
    checks++; if (total_presses !== 32'(exp_total)) begin errors++; $display("FAIL example_total: got %0d want %0d", total_presses, exp_total); end
  endtask

  task automatic test_back_to_back;
    mach_t ms[3]; int want[3]; int lat; bit to, f; int p, nf;
    ms[0] = mk(4, 6, 10'h006, 10'h008, 10'h00A, 10'h004, 10'h00C, 10'h005, 10'h003);
    ms[1] = mk(5, 5, 10'h008, 10'h01D, 10'h00C, 10'h011, 10'h007, 10'h01E, 10'h000);
    ms[2] = mk(6, 4, 10'h02E, 10'h01F, 10'h019, 10'h037, 10'h006, 10'h000, 10'h000);
    want = '{2, 3, 2};
    @(negedge clk); total_clear = 1'b1;
    @(posedge clk); #1; total_clear = 1'b0;
    exp_total = 0;
    checks++; if (total_presses !== 32'd0) begin errors++; $display("FAIL b2b_clear: got %0d want 0", total_presses); end
    for (int i = 0; i < 3; i++) begin
      model(ms[i], f, p, nf);
      run_one(ms[i], lat, to);
      checks++; if (to) begin errors++; $display("FAIL b2b_timeout_%0d: got timeout want out_valid", i); end
      checks++; if (out_presses !== 4'(want[i]) || p != want[i]) begin errors++; $display("FAIL b2b_presses_%0d: got %0d want %0d", i, out_presses, want[i]); end
      checks++; if (effect(ms[i], out_mask) !== ms[i].tgt) begin errors++; $display("FAIL b2b_mask_%0d: got %h want %h", i, effect(ms[i], out_mask), ms[i].tgt); end
      checks++; if (lat != exp_lat(ms[i])) begin errors++; $display("FAIL b2b_latency_%0d: got %0d want %0d", i, lat, exp_lat(ms[i])); end
      @(posedge clk); #1;
      exp_total += p;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); end
    end
    checks++; if (total_presses !== 32'd7) begin errors++; $display("FAIL b2b_total: got %0d want 7", total_presses); end
  endtask

  task automatic test_infeasible;
    mach_t m; int lat; bit to;
    m = mk(1, 1, 10'h001, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
    run_one(m, lat, to);
    checks++; if (to) begin errors++; $display("FAIL infeas_timeout: got timeout want out_valid"); end
    checks++; if (out_infeasible !== 1'b1) begin errors++; $display("FAIL infeas_flag: got %b want 1", out_infeasible); end
    checks++; if (out_presses !== 4'd0) begin errors++; $display("FAIL infeas_presses: got %0d want 0", out_presses); end
    checks++; if (out_mask !== 13'd0) begin errors++; $display("FAIL infeas_mask: got %h want 0", out_mask); end
    checks++; if (lat != 3) begin errors++; $display("FAIL infeas_latency: got %0d want 3", lat); end
    @(posedge clk); #1;
    checks++; if (total_presses !== 32'(exp_total)) begin errors++; $display("FAIL infeas_total: got %0d want %0d", total_presses, exp_total); end
  endtask

  task automatic test_backpressure;
    mach_t m; int lat; bit to, f; int p, nf;
    m = mk(5, 5, 10'h008, 10'h01D, 10'h00C, 10'h011, 10'h007, 10'h01E, 10'h000);
    model(m, f, p, nf);
    out_ready = 1'b0;
    run_one(m, lat, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: got timeout want out_valid"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b want 1", i, out_valid); end
      checks++; if (out_presses !== 4'(p)) begin errors++; $display("FAIL bp_presses_%0d: got %0d want %0d", i, out_presses, p); end
      checks++; if (effect(m, out_mask) !== m.tgt || $countones(out_mask) != p) begin errors++; $display("FAIL bp_mask_%0d: got %h want effect %h", i, out_mask, m.tgt); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
      checks++; if (total_presses !== 32'(exp_total)) begin errors++; $display("FAIL bp_total_%0d: got %0d want %0d", i, total_presses, exp_total); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_total += p;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++; if (total_presses !== 32'(exp_total)) begin errors++; $display("FAIL bp_accept_total: got %0d want %0d", total_presses, exp_total); end
  endtask

  task automatic test_zero_buttons;
    mach_t m; int lat; bit to;
    m = mk(3, 0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
    run_one(m, lat, to);
    checks++; if (to) begin errors++; $display("FAIL zero_timeout: got timeout want out_valid"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL zero_latency: got %0d want 3", lat); end
    checks++; if (out_presses !== 4'd0 || out_mask !== 13'd0 || out_infeasible !== 1'b0) begin
      errors++; $display("FAIL zero_result: got p=%0d m=%h inf=%b want 0/0/0", out_presses, out_mask, out_infeasible);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    mach_t m; int lat; bit to, f; int p, nf;
    for (int it = 0; it < 24; it++) begin
      m.nl = $urandom_range(1, 10); m.nb = $urandom_range(0, 8); m.btn = '0;
      for (int b = 0; b < m.nb; b++) m.btn[b] = 10'($urandom) & lmask(m.nl);
      if ($urandom_range(0, 1) == 1) m.tgt = effect(m, 13'($urandom));
      else m.tgt = 10'($urandom) & lmask(m.nl);
      model(m, f, p, nf);
      checks++; if (nf > 13) begin errors++; $display("FAIL rnd_free_%0d: got %0d free want <= 13", it, nf); end
      run_one(m, lat, to);
      checks++; if (to) begin errors++; $display("FAIL rnd_timeout_%0d: got timeout want out_valid", it); end
      checks++; if (out_infeasible !== !f) begin errors++; $display("FAIL rnd_infeas_%0d: got %b want %b", it, out_infeasible, !f); end
      checks++; if (out_presses !== 4'(f ? p : 0)) begin errors++; $display("FAIL rnd_presses_%0d: got %0d want %0d", it, out_presses, f ? p : 0); end
      if (f) begin
        checks++; if (effect(m, out_mask) !== m.tgt || (out_mask >> m.nb) != 0) begin errors++; $display("FAIL rnd_mask_%0d: got %h want effect %h", it, out_mask, m.tgt); end
      end else begin
        checks++; if (out_mask !== 13'd0) begin errors++; $display("FAIL rnd_mask_%0d: got %h want 0", it, out_mask); end
      end
      checks++; if (lat != exp_lat(m)) begin errors++; $display("FAIL rnd_latency_%0d: got %0d want %0d", it, lat, exp_lat(m)); end
      @(posedge clk); #1;
      if (f) exp_total += p;
      checks++; if (total_presses !== 32'(exp_total)) begin errors++; $display("FAIL rnd_total_%0d: got %0d want %0d", it, total_presses, exp_total); end
    end
  endtask

  task automatic test_reset_mid_enum;
    mach_t mz, m1, m2; int lat, seen; bit to, f; int p, nf;
    mz = mk(3, 6, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
    m1 = mk(4, 6, 10'h006, 10'h008, 10'h00A, 10'h004, 10'h00C, 10'h005, 10'h003);
    m2 = mk(5, 5, 10'h008, 10'h01D, 10'h00C, 10'h011, 10'h007, 10'h01E, 10'h000);
    send_one(mz, to);
    repeat (13) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    checks++; if (total_presses !== 32'd0) begin errors++; $display("FAIL rst_mid_total: got %0d want 0", total_presses); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    exp_total = 0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_stale: got %0d valid cycles want 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %b want 1", in_ready); end
    model(m1, f, p, nf);
    run_one(m1, lat, to);
    @(posedge clk); #1;
    exp_total += p;
    checks++; if (to || total_presses !== 32'(exp_total)) begin errors++; $display("FAIL rst_recover_total: got %0d want %0d", total_presses, exp_total); end
    model(m2, f, p, nf);
    run_one(m2, lat, to);
    total_clear = 1'b1;
    @(posedge clk); #1;
    total_clear = 1'b0;
    exp_total = p;
    checks++; if (to || total_presses !== 32'(exp_total)) begin errors++; $display("FAIL clear_with_emit: got %0d want %0d", total_presses, exp_total); end
  endtask

  initial begin
    test_reset();
    test_example();
    test_back_to_back();
    test_infeasible();
    test_backpressure();
    test_zero_buttons();
    test_random();
    test_reset_mid_enum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
